// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        F_WAIT = 2'b01,
        D_WAIT = 2'b10
    } arbState_t;

    localparam int unsigned DEFAULT_TIMEOUT = 16;
    localparam logic [31:0] BUS_ERR_FILL    = 32'h0;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Wait-state counter for the arbiter; fires once an access has waited TIMEOUT-1 cycles.
module mem_arb_watchdog
    import mem_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic fire
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign fire = enable && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-ported memory between instruction fetch and data access;
// data wins ties, every access passes through IDLE, and a watchdog bounds each wait.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err
);

    arbState_t         state;
    logic [DATA_W-1:0] ifHold;
    logic [DATA_W-1:0] dHold;
    logic              waiting;
    logic              wdFire;
    logic              done;
    logic              timedOut;
    logic              fDone;
    logic              dDone;
    logic [DATA_W-1:0] doneData;

    assign waiting  = (state != IDLE);
    assign done     = waiting && (mem_ready || wdFire);
    // A ready arriving on the watchdog cycle still counts as a normal completion.
    assign timedOut = waiting && wdFire && !mem_ready;
    assign fDone    = (state == F_WAIT) && done;
    assign dDone    = (state == D_WAIT) && done;
    assign doneData = timedOut ? DATA_W'(BUS_ERR_FILL) : mem_rdata;

    assign if_rdata = fDone ? doneData : ifHold;
    assign d_rdata  = dDone ? doneData : dHold;
    assign if_stall = if_req && !fDone;
    assign d_stall  = d_req && !dDone;

    mem_arb_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clear (done || !waiting),
        .enable(waiting),
        .fire  (wdFire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ifHold    <= '0;
            dHold     <= '0;
            bus_err   <= 1'b0;
        end else begin
            mem_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (d_req) begin
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_we    <= d_we;
                        mem_en    <= 1'b1;
                        state     <= D_WAIT;
                    end else if (if_req) begin
                        mem_addr <= if_addr;
                        mem_we   <= 1'b0;
                        mem_en   <= 1'b1;
                        state    <= F_WAIT;
                    end
                end
                F_WAIT: begin
                    if (done) begin
                        ifHold <= doneData;
                        state  <= IDLE;
                    end
                end
                D_WAIT: begin
                    if (done) begin
                        dHold <= doneData;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (timedOut) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios followed by two random requesters.
module tb_mem_arbiter;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_stall;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_err;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_stall (if_stall),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_stall  (d_stall),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .bus_err  (bus_err)
    );

    typedef struct {
        logic        care;
        logic [31:0] data;
    } exp_t;

    int   nChecks = 0;
    int   nPass = 0;
    exp_t ifExp[$];
    exp_t dExp[$];
    logic [31:0] refMem[logic [31:0]];
    logic [31:0] memArr[logic [31:0]];

    int memLat = -1;
    bit memSilent = 1'b0;
    bit strayReq = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Power-on memory contents.
    function automatic logic [31:0] initWord(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Memory model: ready arrives memLat cycles after the mem_en cycle.
    initial begin
        int          cnt;
        logic [31:0] rAddr;
        cnt = 0;
        rAddr = '0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                cnt = 0;
                mem_ready = 1'b0;
                continue;
            end
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = memArr.exists(rAddr) ? memArr[rAddr] : initWord(rAddr);
                end
            end else if (strayReq) begin
                mem_ready = 1'b1;
                mem_rdata = 32'hDEAD_BEEF;
                strayReq = 1'b0;
            end
            if (mem_en) begin
                rAddr = mem_addr;
                if (mem_we) memArr[mem_addr] = mem_wdata;
                if (!memSilent) cnt = (memLat > 0) ? memLat : int'($urandom_range(1, 4));
            end
        end
    end

    // Monitor: completions against the scoreboard, grants against the prior cycle's requests.
    initial begin
        bit          pv;
        logic        pIf, pD, pWe, pEn;
        logic [31:0] pIfA, pDA, pWd;
        exp_t        e;
        pv = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pv = 1'b0;
                continue;
            end
            if (if_req && !if_stall) begin
                if (ifExp.size() == 0) check("if_unexpected_done", if_stall, 1);
                else begin
                    e = ifExp.pop_front();
                    if (e.care) check("if_rdata", if_rdata, e.data);
                end
            end
            if (d_req && !d_stall) begin
                if (dExp.size() == 0) check("d_unexpected_done", d_stall, 1);
                else begin
                    e = dExp.pop_front();
                    if (e.care) check("d_rdata", d_rdata, e.data);
                end
            end
            if (mem_en && pv) begin
                check("mem_en_pulse", pEn, 0);
                if (pD) begin
                    check("grant_d_addr", mem_addr, pDA);
                    check("grant_d_we", mem_we, pWe);
                    if (pWe) check("grant_d_wdata", mem_wdata, pWd);
                end else begin
                    check("grant_had_req", pIf, 1);
                    check("grant_if_addr", mem_addr, pIfA);
                    check("grant_if_we", mem_we, 0);
                end
            end
            pv = 1'b1;
            pIf = if_req; pIfA = if_addr;
            pD = d_req; pDA = d_addr; pWe = d_we; pWd = d_wdata; pEn = mem_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issueFetch(input logic [31:0] a, input bit toExpected);
        if_req = 1'b1;
        if_addr = a;
        ifExp.push_back('{1'b1, toExpected ? 32'h0 : initWord(a)});
    endtask

    task automatic issueData(input bit we, input logic [31:0] a, input logic [31:0] wd);
        d_req = 1'b1;
        d_we = we;
        d_addr = a;
        d_wdata = wd;
        if (we) begin
            refMem[a] = wd;
            dExp.push_back('{1'b0, 32'h0});
        end else begin
            dExp.push_back('{1'b1, refMem.exists(a) ? refMem[a] : initWord(a)});
        end
    endtask

    task automatic waitIfServed(output int stalled);
        stalled = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!if_stall) return;
            stalled++;
        end
        check("if_served_in_bound", if_stall, 0);
    endtask

    task automatic waitDServed(output int stalled);
        stalled = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!d_stall) return;
            stalled++;
        end
        check("d_served_in_bound", d_stall, 0);
    endtask

    task automatic waitMemEn();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_en) return;
        end
        check("mem_en_in_bound", mem_en, 1);
    endtask

    initial begin
        int s;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_stalls", {if_stall, d_stall}, 0);

        // Fetch only, ready two cycles after mem_en
        memLat = 2;
        tick();
        issueFetch(32'h0040_0000, 1'b0);
        waitIfServed(s);
        check("fetch_stall_cycles", s, 3);
        check("fetch_rdata", if_rdata, 32'h2008_0005);
        check("fetch_mem_addr", mem_addr, 32'h0040_0000);
        tick();
        if_req = 1'b0;

        // Simultaneous requests: data first
        memLat = -1;
        tick();
        issueData(1'b0, 32'h1001_0004, 32'h0);
        issueFetch(32'h0040_0010, 1'b0);
        waitDServed(s);
        check("sim_if_stall_during_data", if_stall, 1);
        tick();
        d_req = 1'b0;
        waitIfServed(s);
        tick();
        if_req = 1'b0;

        // Store then load back
        memLat = 2;
        tick();
        issueData(1'b1, 32'h1001_0008, 32'hCAFE_F00D);
        waitDServed(s);
        check("store_mem_we", mem_we, 1);
        check("store_mem_wdata", mem_wdata, 32'hCAFE_F00D);
        tick();
        issueData(1'b0, 32'h1001_0008, 32'h0);
        waitDServed(s);
        check("load_after_store", d_rdata, 32'hCAFE_F00D);
        tick();
        d_req = 1'b0;

        // Timeout on a fetch
        memSilent = 1'b1;
        tick();
        issueFetch(32'h0040_0020, 1'b1);
        waitIfServed(s);
        check("timeout_stall_cycles", s, TO);
        check("timeout_rdata", if_rdata, 0);
        tick();
        if_req = 1'b0;
        memSilent = 1'b0;
        @(negedge clk);
        check("timeout_bus_err", bus_err, 1);
        strayReq = 1'b1;
        @(negedge clk);
        check("stray_if_rdata", if_rdata, 0);
        @(negedge clk);
        check("stray_no_mem_en", mem_en, 0);
        check("stray_bus_err_sticky", bus_err, 1);
        check("stray_if_hold", if_rdata, 0);

        // Reset asserted in D_WAIT
        memSilent = 1'b1;
        tick();
        issueData(1'b0, 32'h1001_000C, 32'h0);
        waitMemEn();
        #2 rst = 1'b0;
        #1;
        check("rstmid_mem_en", mem_en, 0);
        check("rstmid_bus_err", bus_err, 0);
        check("rstmid_d_stall", d_stall, 1);
        check("rstmid_d_rdata", d_rdata, 0);
        memSilent = 1'b0;
        memLat = 2;
        @(negedge clk);
        #2 rst = 1'b1;
        waitDServed(s);
        tick();
        d_req = 1'b0;

        // Fetch flushed mid-access, data queued behind it
        memLat = 3;
        tick();
        if_req = 1'b1;
        if_addr = 32'h0040_0030;
        waitMemEn();
        tick();
        if_req = 1'b0;
        issueData(1'b0, 32'h1001_0010, 32'h0);
        @(negedge clk);
        check("flush_no_if_stall", if_stall, 0);
        check("flush_d_stall_held", d_stall, 1);
        waitDServed(s);
        check("flush_if_hold", if_rdata, initWord(32'h0040_0030));
        tick();
        d_req = 1'b0;

        // Random concurrent requesters
        memLat = -1;
        fork
            begin
                int sf;
                for (int n = 0; n < 60; n++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    issueFetch(32'h0040_0000 + 32'(4 * $urandom_range(0, 63)), 1'b0);
                    waitIfServed(sf);
                    tick();
                    if_req = 1'b0;
                end
            end
            begin
                int sd;
                for (int n = 0; n < 60; n++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    issueData(1'($urandom_range(0, 1)),
                              32'h1001_0000 + 32'(4 * $urandom_range(0, 7)), $urandom);
                    waitDServed(sd);
                    tick();
                    d_req = 1'b0;
                end
            end
        join
        repeat (10) tick();
        check("if_queue_drained", ifExp.size(), 0);
        check("d_queue_drained", dExp.size(), 0);
        check("random_no_bus_err", bus_err, 0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
